// File: rtl/ltpi_frame_rx_align.sv
// LTPI receive framing: K28.5 comma hunt, fixed-length frame alignment, CRC-8 check and lock tracking.
// Define LTPI_RX_ERR_CNT_EN to build the saturating bad-frame counter behind crc_err_cnt/clr_cnt.
module ltpi_frame_rx_align #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] CRC_POLY  = 8'h07,
  parameter int         LOCK_CNT  = 7,
  parameter int         LOSS_CNT  = 3,
  localparam int        IW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_symbol,
  input  logic          rx_k,
  input  logic          rx_dec_err,
  output logic          frm_valid,
  output logic [7:0]    frm_data,
  output logic [IW-1:0] frm_idx,
  output logic          frm_eof,
  output logic          frm_crc_ok,
  output logic          aligned,
  output logic [15:0]   crc_err_cnt,
  input  logic          clr_cnt
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    crc_q, crc_d;
  logic          fbad_q, fbad_d;
  logic [7:0]    good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic          frm_valid_q, frm_valid_d, frm_eof_q, frm_eof_d, frm_crc_ok_q, frm_crc_ok_d;
  logic [7:0]    frm_data_q, frm_data_d;
  logic [IW-1:0] frm_idx_q, frm_idx_d;
  logic          aligned_q, aligned_d;
  logic          comma, is_last, crc_ok, frame_bad_evt;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction

  assign comma   = rx_valid && rx_k && (rx_symbol == 8'hBC);
  assign is_last = (idx_q == LAST);
  // Verdict for the frame whose CRC byte is on the input right now.
  assign crc_ok  = !fbad_q && !rx_dec_err && !rx_k && (rx_symbol == crc_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    fbad_d        = fbad_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    frm_valid_d   = 1'b0;
    frm_data_d    = '0;
    frm_idx_d     = '0;
    frm_eof_d     = 1'b0;
    frm_crc_ok_d  = 1'b0;
    aligned_d     = (state_q == LOCKED);
    frame_bad_evt = 1'b0;
    if (rx_valid) begin
      if (state_q == HUNT) begin
        if (comma) begin
          state_d = SYNC;
          idx_d   = IW'(1);
          crc_d   = '0;
          fbad_d  = 1'b0;
        end
      end else begin
        idx_d = is_last ? '0 : idx_q + 1'b1;
        if (state_q == LOCKED) begin
          frm_valid_d  = 1'b1;
          frm_data_d   = rx_symbol;
          frm_idx_d    = idx_q;
          frm_eof_d    = is_last;
          frm_crc_ok_d = is_last && crc_ok;
        end
        if (idx_q == '0) begin
          crc_d  = '0;
          fbad_d = !comma;
          if (!comma && state_q == SYNC) begin
            state_d    = HUNT;
            good_cnt_d = '0;
            idx_d      = '0;
          end
        end else if (comma && state_q == SYNC) begin
          // Still acquiring: a stray comma is taken as the true frame start.
          idx_d  = IW'(1);
          crc_d  = '0;
          fbad_d = 1'b0;
        end else if (!is_last) begin
          crc_d  = crc8_byte(crc_q, rx_symbol);
          fbad_d = fbad_q | rx_dec_err | rx_k;
        end else if (state_q == SYNC) begin
          if (!crc_ok) begin
            frame_bad_evt = 1'b1;
            state_d       = HUNT;
            good_cnt_d    = '0;
          end else if (good_cnt_q == 8'(LOCK_CNT - 1)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end else begin
          if (crc_ok) begin
            bad_cnt_d = '0;
          end else begin
            frame_bad_evt = 1'b1;
            if (bad_cnt_q == 8'(LOSS_CNT - 1)) begin
              state_d   = HUNT;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      crc_q        <= '0;
      fbad_q       <= 1'b0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      frm_valid_q  <= 1'b0;
      frm_data_q   <= '0;
      frm_idx_q    <= '0;
      frm_eof_q    <= 1'b0;
      frm_crc_ok_q <= 1'b0;
      aligned_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      crc_q        <= crc_d;
      fbad_q       <= fbad_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      frm_valid_q  <= frm_valid_d;
      frm_data_q   <= frm_data_d;
      frm_idx_q    <= frm_idx_d;
      frm_eof_q    <= frm_eof_d;
      frm_crc_ok_q <= frm_crc_ok_d;
      aligned_q    <= aligned_d;
    end
  end

  assign frm_valid  = frm_valid_q;
  assign frm_data   = frm_data_q;
  assign frm_idx    = frm_idx_q;
  assign frm_eof    = frm_eof_q;
  assign frm_crc_ok = frm_crc_ok_q;
  assign aligned    = aligned_q;

`ifdef LTPI_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt)                                    err_cnt_d = '0;
    else if (frame_bad_evt && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign crc_err_cnt = err_cnt_q;
`else
  logic [1:0] unused_cnt_in;
  assign unused_cnt_in = {clr_cnt, frame_bad_evt};
  assign crc_err_cnt   = '0;
`endif
endmodule

// File: tb/tb_ltpi_frame_rx_align.sv
// Randomized bench for ltpi_frame_rx_align: frame-level reference model feeds a scoreboard queue,
// a free-running monitor pops and compares every delivered byte and the aligned flag.
module tb_ltpi_frame_rx_align;
  localparam int         FL   = 16;
  localparam int         IW   = $clog2(FL);
  localparam int         LOCK = 7;
  localparam int         LOSS = 3;
  localparam logic [7:0] POLY = 8'h07;

  logic          clk, reset_n, rx_valid, rx_k, rx_dec_err, clr_cnt;
  logic [7:0]    rx_symbol;
  logic          frm_valid, frm_eof, frm_crc_ok, aligned;
  logic [7:0]    frm_data;
  logic [IW-1:0] frm_idx;
  logic [15:0]   crc_err_cnt;

  ltpi_frame_rx_align dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_symbol(rx_symbol), .rx_k(rx_k),
    .rx_dec_err(rx_dec_err), .frm_valid(frm_valid), .frm_data(frm_data), .frm_idx(frm_idx),
    .frm_eof(frm_eof), .frm_crc_ok(frm_crc_ok), .aligned(aligned), .crc_err_cnt(crc_err_cnt),
    .clr_cnt(clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0]    d;
    logic [IW-1:0] idx;
    logic          eof;
    logic          ok;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0, n_pass = 0;
  int         st = 0, pos = 0, good_n = 0, bad_n = 0, m_errs = 0;  // st: 0 hunt, 1 sync, 2 locked
  logic [7:0] b_sym[FL];
  bit         b_k[FL], b_e[FL];
  bit         gaps = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // CRC as remainder of the zero-augmented message divided by x^8+POLY (init 0, MSB first).
  function automatic logic [7:0] crc_ref(input logic [7:0] d[FL]);
    logic [8:0] rem = '0;
    for (int i = 1; i <= FL - 2; i++)
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], d[i][b]};
        if (rem[8]) rem ^= {1'b1, POLY};
      end
    for (int b = 0; b < 8; b++) begin
      rem = {rem[7:0], 1'b0};
      if (rem[8]) rem ^= {1'b1, POLY};
    end
    return rem[7:0];
  endfunction

  function automatic bit frame_good();
    bit g = b_k[0] && (b_sym[0] == 8'hBC);
    for (int i = 1; i < FL; i++) if (b_k[i] || b_e[i]) g = 0;
    return g && (crc_ref(b_sym) == b_sym[FL-1]);
  endfunction

  task automatic model_step(input logic [7:0] s, input bit k, input bit e);
    bit   comma = k && (s == 8'hBC);
    bit   good;
    exp_t x;
    if (st == 0) begin
      if (comma) begin st = 1; pos = 1; b_sym[0] = s; b_k[0] = 1; end
      return;
    end
    if (st == 1 && pos != 0 && comma) begin pos = 1; b_sym[0] = s; b_k[0] = 1; return; end
    if (st == 1 && pos == 0 && !comma) begin st = 0; good_n = 0; return; end
    b_sym[pos] = s; b_k[pos] = k; b_e[pos] = e;
    good = (pos == FL - 1) && frame_good();
    if (st == 2) begin
      x.d = s; x.idx = IW'(pos); x.eof = (pos == FL - 1); x.ok = good;
      q.push_back(x);
    end
    if (pos != FL - 1) begin pos++; return; end
    pos = 0;
    if (!good && m_errs < 16'hFFFF) m_errs++;
    if (st == 1) begin
      if (!good) begin st = 0; good_n = 0; end
      else if (++good_n == LOCK) begin st = 2; good_n = 0; bad_n = 0; end
    end else begin
      if (good) bad_n = 0;
      else if (++bad_n == LOSS) begin st = 0; bad_n = 0; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (clr_cnt) m_errs = 0;
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [7:0] s, input bit k, input bit e);
    if (gaps) while ($urandom_range(1, 0) == 1) idle(1);
    rx_valid = 1; rx_symbol = s; rx_k = k; rx_dec_err = e;
    model_step(s, k, e);
    if (clr_cnt) m_errs = 0;
    @(negedge clk);
    // Junk (often a comma) while invalid must be ignored.
    rx_valid   = 0;
    rx_k       = 1'($urandom_range(1, 0));
    rx_symbol  = $urandom_range(1, 0) ? 8'hBC : 8'($urandom);
    rx_dec_err = 1'($urandom_range(1, 0));
  endtask

  // mode: 0 good, 1 bad CRC, 2 dec error, 3 missing comma, 4 comma inside the payload
  task automatic send_frame(input int mode);
    logic [7:0] d[FL];
    int         p = $urandom_range(FL - 2, 1);
    d[0] = 8'hBC;
    for (int i = 1; i < FL - 1; i++) d[i] = 8'($urandom);
    d[FL-1] = crc_ref(d);
    if (mode == 1) d[FL-1] ^= 8'(1 << $urandom_range(7, 0));
    if (mode == 3) drive(8'($urandom) & 8'h7F, 0, 0);
    else           drive(8'hBC, 1, 0);
    for (int i = 1; i < FL; i++) begin
      if (mode == 4 && i == p) drive(8'hBC, 1, 0);
      else                     drive(d[i], 0, (mode == 2 && i == p));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("reset_outputs", {frm_valid, frm_data, frm_idx, frm_eof, frm_crc_ok, aligned, crc_err_cnt}, '0);
    st = 0; pos = 0; good_n = 0; bad_n = 0; m_errs = 0;
    q.delete();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic chk_cnt(input string nm);
`ifdef LTPI_RX_ERR_CNT_EN
    chk(nm, crc_err_cnt, 32'(m_errs));
`else
    chk(nm, crc_err_cnt, 0);
`endif
  endtask

  // Monitor: one cycle after the symbol the DUT must present exactly what the model queued.
  initial begin
    bit   lk_prev = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) lk_prev = 0;
      else begin
        chk("aligned", aligned, lk_prev);
        lk_prev = (st == 2);
        chk("frm_valid", frm_valid, q.size() != 0);
        if (frm_valid && q.size() != 0) begin
          e = q.pop_front();
          chk("frame_byte", {frm_data, frm_idx, frm_eof, frm_crc_ok}, e);
        end else if (q.size() != 0) begin
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] s;
    reset_n = 1; rx_valid = 0; rx_symbol = 0; rx_k = 0; rx_dec_err = 0; clr_cnt = 0;
    #1 reset_n = 0;
    #1 chk("reset_outputs", {frm_valid, frm_data, frm_idx, frm_eof, frm_crc_ok, aligned, crc_err_cnt}, '0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    // Acquire: 7 frames to lock, 8th forwarded.
    repeat (8) send_frame(0);
    idle(2); chk("aligned_after_lock", aligned, 1);

    // Three bad CRCs drop lock.
    repeat (3) send_frame(1);
    idle(2); chk("aligned_after_loss", aligned, 0);
    chk_cnt("err_cnt_after_loss");

    // Relock, then bad/bad/good/bad/bad keeps lock.
    repeat (8) send_frame(0);
    send_frame(1); send_frame(1); send_frame(0); send_frame(1); send_frame(1); send_frame(0);
    idle(2); chk("aligned_interleaved", aligned, 1);
    chk_cnt("err_cnt_interleaved");

    // Hunt through random junk, a truncated frame, then lock at that offset.
    do_reset();
    n = $urandom_range(20, 1);
    for (int i = 0; i < n; i++) begin
      s = 8'($urandom);
      if (s == 8'hBC) s = 8'h00;
      drive(s, 1'($urandom_range(1, 0)), 0);
    end
    drive(8'hBC, 1, 0);
    repeat (3) drive(8'($urandom), 0, 0);
    repeat (8) send_frame(0);
    idle(2); chk("aligned_offset", aligned, 1);

    // 50% rx_valid gaps, with single bad frames of each flavour while locked.
    gaps = 1;
    do_reset();
    repeat (8) send_frame(0);
    send_frame(2); send_frame(0); send_frame(3); send_frame(0); send_frame(4); send_frame(0);
    gaps = 0;
    idle(2); chk("aligned_gapped", aligned, 1);

    // Reset mid-frame while locked; relock needs 7 fresh frames.
    drive(8'hBC, 1, 0);
    repeat (5) drive(8'($urandom), 0, 0);
    do_reset();
    repeat (6) send_frame(0);
    idle(2); chk("aligned_after_6", aligned, 0);
    send_frame(0);
    idle(2); chk("aligned_after_7", aligned, 1);
    send_frame(0);

    // Error counter increment, then clear winning over a concurrent bad frame.
    send_frame(1);
    idle(2); chk_cnt("err_cnt_one");
    clr_cnt = 1;
    send_frame(1);
    idle(1);
    clr_cnt = 0;
    idle(2); chk_cnt("err_cnt_cleared");

    idle(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
